// File: rtl/sm_cmp_pkg.sv
// Shared constants for the streaming sign-magnitude comparator slice.
package sm_cmp_pkg;

  // Per-pair number format selectors (2'b11 is handled like unsigned)
  localparam logic [1:0] MODE_SM  = 2'b00;
  localparam logic [1:0] MODE_TC  = 2'b01;
  localparam logic [1:0] MODE_UNS = 2'b10;

  // Compare result encodings; 2'b11 is never produced
  localparam logic [1:0] RES_EQ  = 2'b00;
  localparam logic [1:0] RES_BGT = 2'b01;
  localparam logic [1:0] RES_AGT = 2'b10;

endpackage

// File: rtl/sm_key_norm.sv
// Maps an operand in any supported format onto an unsigned key whose
// ordering matches the numeric ordering of the original value.
module sm_key_norm
  import sm_cmp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [1:0]   mode,
  output logic [W-1:0] key
);

  localparam logic [W-1:0] BIAS = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] mag;

  assign mag = {1'b0, x[W-2:0]};

  // Bias the value around 2^(W-1) so that negatives sort below positives
  always_comb begin
    key = x;
    case (mode)
      MODE_SM: begin
        if (mag == '0)
          key = BIAS;
        else if (x[W-1])
          key = BIAS - mag;
        else
          key = BIAS + mag;
      end
      MODE_TC: key = x ^ BIAS;
      default: key = x;
    endcase
  end

endmodule

// File: rtl/sm_compare_stream.sv
// Streaming comparator: two-stage back-pressured pipeline producing one
// compare result per operand pair, plus windowed result statistics.
module sm_compare_stream
  import sm_cmp_pkg::*;
#(
  parameter  int W   = 8,
  parameter  int WIN = 16,
  localparam int CW  = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [1:0]    mode,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [1:0]    res,
  input  logic          win_clr,
  output logic          win_valid,
  output logic [CW-1:0] win_gt,
  output logic [CW-1:0] win_lt,
  output logic [CW-1:0] win_eq
);

  logic          en1;
  logic          en2;
  logic          xfer;
  logic          win_done;
  logic          s1_valid;
  logic [W-1:0]  key_a;
  logic [W-1:0]  key_b;
  logic [W-1:0]  ka;
  logic [W-1:0]  kb;
  logic [1:0]    cmp;
  logic [CW-1:0] cnt_gt;
  logic [CW-1:0] cnt_lt;
  logic [CW-1:0] cnt_eq;
  logic [CW-1:0] cnt_res;
  logic [CW-1:0] nxt_gt;
  logic [CW-1:0] nxt_lt;
  logic [CW-1:0] nxt_eq;
  logic [CW-1:0] nxt_res;

  assign en2      = !res_valid || res_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;
  assign xfer     = res_valid && res_ready;

  sm_key_norm #(.W(W)) u_norm_a (.x(a), .mode(mode), .key(key_a));
  sm_key_norm #(.W(W)) u_norm_b (.x(b), .mode(mode), .key(key_b));

  // Stage 1: capture normalised keys whenever the stage can advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      ka       <= '0;
      kb       <= '0;
    end else if (en1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        ka <= key_a;
        kb <= key_b;
      end
    end
  end

  // Unsigned key comparison gives the signed/format-aware result
  always_comb begin
    cmp = RES_EQ;
    if (ka > kb)
      cmp = RES_AGT;
    else if (ka < kb)
      cmp = RES_BGT;
  end

  // Stage 2: result register, frozen while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res       <= RES_EQ;
    end else if (en2) begin
      res_valid <= s1_valid;
      if (s1_valid)
        res <= cmp;
    end
  end

  // Counter values including the result currently being transferred
  always_comb begin
    nxt_gt   = cnt_gt + CW'(res == RES_AGT);
    nxt_lt   = cnt_lt + CW'(res == RES_BGT);
    nxt_eq   = cnt_eq + CW'(res == RES_EQ);
    nxt_res  = cnt_res + CW'(1);
    win_done = xfer && !win_clr && (cnt_res == CW'(WIN - 1));
  end

  // Window accounting; a clear overrides both counting and completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_gt    <= '0;
      cnt_lt    <= '0;
      cnt_eq    <= '0;
      cnt_res   <= '0;
      win_valid <= 1'b0;
      win_gt    <= '0;
      win_lt    <= '0;
      win_eq    <= '0;
    end else begin
      win_valid <= win_done;
      if (win_clr) begin
        cnt_gt  <= '0;
        cnt_lt  <= '0;
        cnt_eq  <= '0;
        cnt_res <= '0;
      end else if (win_done) begin
        win_gt  <= nxt_gt;
        win_lt  <= nxt_lt;
        win_eq  <= nxt_eq;
        cnt_gt  <= '0;
        cnt_lt  <= '0;
        cnt_eq  <= '0;
        cnt_res <= '0;
      end else if (xfer) begin
        cnt_gt  <= nxt_gt;
        cnt_lt  <= nxt_lt;
        cnt_eq  <= nxt_eq;
        cnt_res <= nxt_res;
      end
    end
  end

endmodule

// File: tb/tb_sm_compare_stream.sv
// Scoreboard bench for sm_compare_stream (W=8, WIN=4).
module tb_sm_compare_stream;
  import sm_cmp_pkg::*;

  localparam int W   = 8;
  localparam int WIN = 4;
  localparam int CW  = $clog2(WIN + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    mode;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res;
  logic          win_clr;
  logic          win_valid;
  logic [CW-1:0] win_gt;
  logic [CW-1:0] win_lt;
  logic [CW-1:0] win_eq;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  bit lat_chk    = 1'b0;

  logic [1:0] exp_q[$];
  int         acc_q[$];

  int m_gt = 0, m_lt = 0, m_eq = 0, m_n = 0;
  int h_gt = 0, h_lt = 0, h_eq = 0;
  bit pend = 1'b0;

  sm_compare_stream #(.W(W), .WIN(WIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .res_valid(res_valid), .res_ready(res_ready),
    .res(res), .win_clr(win_clr), .win_valid(win_valid),
    .win_gt(win_gt), .win_lt(win_lt), .win_eq(win_eq)
  );

  // Free-running clock and cycle counter used for latency checks
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one pair; the expected result is queued when it is accepted
  task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic [1:0] vm, input logic [1:0] vexp);
    bit done = 1'b0;
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    mode     = vm;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(vexp);
        acc_q.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: got no in_ready, expected accept of %0h/%0h", va, vb);
    end
  endtask

  // Wait until every queued result has left the DUT
  task automatic drainResults();
    int i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Realign window accounting while the pipeline is idle
  task automatic clearWindow();
    win_clr = 1'b1;
    @(posedge clk);
    #1;
    win_clr = 1'b0;
  endtask

  // Monitor: pops expected results on transfers and tracks window pulses
  always @(negedge clk) begin
    logic [1:0] e;
    int         ac;
    if (rst) begin
      m_gt = 0; m_lt = 0; m_eq = 0; m_n = 0;
      h_gt = 0; h_lt = 0; h_eq = 0;
      pend = 1'b0;
    end else begin
      checkOutput("win_valid", win_valid, pend);
      if (pend) begin
        checkOutput("win_gt", win_gt, h_gt);
        checkOutput("win_lt", win_lt, h_lt);
        checkOutput("win_eq", win_eq, h_eq);
      end
      pend = 1'b0;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_result: got res=%0h, expected no result", res);
        end else begin
          e  = exp_q.pop_front();
          ac = acc_q.pop_front();
          checkOutput("res", res, e);
          if (lat_chk)
            checkOutput("latency", cyc - ac, 2);
          if (!win_clr) begin
            if (e == RES_AGT) m_gt++;
            else if (e == RES_BGT) m_lt++;
            else m_eq++;
            m_n++;
            if (m_n == WIN) begin
              h_gt = m_gt; h_lt = m_lt; h_eq = m_eq;
              pend = 1'b1;
              m_gt = 0; m_lt = 0; m_eq = 0; m_n = 0;
            end
          end
        end
      end
      if (win_clr) begin
        m_gt = 0; m_lt = 0; m_eq = 0; m_n = 0;
      end
    end
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    mode      = MODE_SM;
    res_ready = 1'b1;
    win_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res", res, 0);
    checkOutput("rst_win_valid", win_valid, 0);
    checkOutput("rst_win_gt", win_gt, 0);
    checkOutput("rst_win_lt", win_lt, 0);
    checkOutput("rst_win_eq", win_eq, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] format tests");
    lat_chk = 1'b1;
    applyStimulus(8'h85, 8'h03, MODE_SM, RES_BGT);
    applyStimulus(8'h80, 8'h00, MODE_SM, RES_EQ);
    applyStimulus(8'h83, 8'h85, MODE_SM, RES_AGT);
    applyStimulus(8'hFB, 8'h03, MODE_TC, RES_BGT);
    applyStimulus(8'hFB, 8'h03, MODE_UNS, RES_AGT);
    applyStimulus(8'hFB, 8'h03, 2'b11, RES_AGT);
    applyStimulus(8'h7F, 8'h80, MODE_TC, RES_AGT);
    applyStimulus(8'h00, 8'h81, MODE_SM, RES_AGT);
    drainResults();
    clearWindow();

    $display("[TB] back-pressure");
    lat_chk   = 1'b0;
    res_ready = 1'b0;
    fork
      begin
        applyStimulus(8'h01, 8'h02, MODE_UNS, RES_BGT);
        applyStimulus(8'h05, 8'h05, MODE_TC, RES_EQ);
        applyStimulus(8'h7F, 8'h80, MODE_TC, RES_AGT);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_in_ready", in_ready, 0);
        checkOutput("bp_res_valid", res_valid, 1);
        checkOutput("bp_res", res, RES_BGT);
        repeat (3) @(negedge clk);
        checkOutput("bp_res_held", res, RES_BGT);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
      end
    join
    drainResults();
    clearWindow();

    $display("[TB] window accounting");
    lat_chk = 1'b1;
    applyStimulus(8'h02, 8'h01, MODE_UNS, RES_AGT);
    applyStimulus(8'h03, 8'h01, MODE_UNS, RES_AGT);
    applyStimulus(8'h01, 8'h02, MODE_UNS, RES_BGT);
    applyStimulus(8'h04, 8'h04, MODE_UNS, RES_EQ);
    drainResults();
    checkOutput("win1_gt", win_gt, 2);
    checkOutput("win1_lt", win_lt, 1);
    checkOutput("win1_eq", win_eq, 1);
    for (int i = 0; i < WIN; i++)
      applyStimulus(8'h10, 8'h10, MODE_SM, RES_EQ);
    drainResults();
    checkOutput("win2_gt", win_gt, 0);
    checkOutput("win2_lt", win_lt, 0);
    checkOutput("win2_eq", win_eq, 4);

    $display("[TB] window clear on completing transfer");
    lat_chk = 1'b0;
    applyStimulus(8'h20, 8'h10, MODE_UNS, RES_AGT);
    applyStimulus(8'h10, 8'h20, MODE_UNS, RES_BGT);
    applyStimulus(8'h20, 8'h10, MODE_UNS, RES_AGT);
    drainResults();
    res_ready = 1'b0;
    applyStimulus(8'h01, 8'h01, MODE_UNS, RES_EQ);
    repeat (3) @(posedge clk);
    #1;
    res_ready = 1'b1;
    win_clr   = 1'b1;
    @(posedge clk);
    #1;
    win_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("clr_win_gt", win_gt, 0);
    checkOutput("clr_win_lt", win_lt, 0);
    checkOutput("clr_win_eq", win_eq, 4);
    applyStimulus(8'h83, 8'h81, MODE_TC, RES_AGT);
    applyStimulus(8'h05, 8'h85, MODE_SM, RES_AGT);
    applyStimulus(8'hFF, 8'h00, MODE_UNS, RES_AGT);
    applyStimulus(8'hFF, 8'h00, MODE_TC, RES_BGT);
    drainResults();
    checkOutput("win3_gt", win_gt, 3);
    checkOutput("win3_lt", win_lt, 1);
    checkOutput("win3_eq", win_eq, 0);

    $display("[TB] asynchronous reset mid-cycle");
    applyStimulus(8'h09, 8'h02, MODE_UNS, RES_AGT);
    drainResults();
    res_ready = 1'b0;
    applyStimulus(8'h02, 8'h09, MODE_UNS, RES_BGT);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    checkOutput("arst_res_valid", res_valid, 0);
    checkOutput("arst_res", res, 0);
    checkOutput("arst_win_valid", win_valid, 0);
    checkOutput("arst_win_gt", win_gt, 0);
    checkOutput("arst_win_lt", win_lt, 0);
    checkOutput("arst_win_eq", win_eq, 0);
    checkOutput("arst_in_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    res_ready = 1'b1;
    lat_chk   = 1'b1;
    applyStimulus(8'h80, 8'h01, MODE_SM, RES_BGT);
    drainResults();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
